// File: rtl/soc_pkg.sv
// Shared constants and encodings for the SoC memory / memory-mapped I/O slave.
package soc_pkg;

   localparam int unsigned IO_BIT           = 22;
   localparam int unsigned IO_LEDS_BIT      = 0;
   localparam int unsigned IO_UART_DATA_BIT = 1;
   localparam int unsigned IO_UART_CTRL_BIT = 2;
   localparam int unsigned UART_BUSY_BIT    = 9;

   // Start bit + 8 data bits + stop bit.
   localparam int unsigned UART_FRAME_BITS  = 10;

   typedef enum logic {
      UartIdle,
      UartShift
   } uart_state_e;

   // Source of the registered read data, captured at the strobe edge.
   typedef enum logic [1:0] {
      RdZero,
      RdRam,
      RdIo
   } rd_src_e;

endpackage

// File: rtl/soc_memory_if.sv
// Processor memory bus: word-addressed read strobe plus byte-masked write path.
interface soc_memory_if;

   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_rstrb;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   modport master (
      output mem_addr,
      output mem_rstrb,
      output mem_wdata,
      output mem_wmask,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_rstrb,
      input  mem_wdata,
      input  mem_wmask,
      output mem_rdata
   );

endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit, each held for one baud period.
module uart_tx_8n1
   import soc_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 12000000,
   parameter int unsigned BAUD        = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned DIVIDER = CLK_FREQ_HZ / BAUD;
   localparam int unsigned CNT_W   = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVIDER - 1);
   localparam logic [3:0]       BIT_LAST  = 4'(UART_FRAME_BITS - 1);

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] baud_q;
   logic [3:0]       bit_q;
   logic [9:0]       shift_q;
   logic             start;
   logic             baud_tick;
   logic             frame_done;

   assign start      = valid && (state_q == UartIdle);
   assign baud_tick  = (baud_q == BAUD_LAST);
   assign frame_done = baud_tick && (bit_q == BIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= UartIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         UartIdle:  if (valid)      state_d = UartShift;
         UartShift: if (frame_done) state_d = UartIdle;
      endcase
   end

   always_comb begin
      tx   = 1'b1;
      busy = 1'b0;
      if (state_q == UartShift) begin
         tx   = shift_q[0];
         busy = 1'b1;
      end
   end

   // Whole frame is preloaded so each baud tick is a plain shift toward tx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '1;
      end else if (start) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= {1'b1, data, 1'b0};
      end else if (state_q == UartShift) begin
         if (baud_tick) begin
            baud_q  <= '0;
            bit_q   <= bit_q + 4'd1;
            shift_q <= {1'b1, shift_q[9:1]};
         end else begin
            baud_q  <= baud_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/soc_memory.sv
// Unified instruction/data RAM with LED register and UART transmitter mapped at bit 22.
module soc_memory
   import soc_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1536,
   parameter string       INIT_FILE   = "firmware.hex",
   parameter int unsigned CLK_FREQ_HZ = 12000000,
   parameter int unsigned BAUD        = 115200
) (
   input  logic         clk,
   input  logic         rst_n,
   soc_memory_if.slave  bus,
   output logic [4:0]   leds,
   output logic         uart_tx,
   output logic         uart_busy
);

   localparam int unsigned ADDR_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [2:0] LEDS_WORD      = 3'(1 << IO_LEDS_BIT);
   localparam logic [2:0] UART_DATA_WORD = 3'(1 << IO_UART_DATA_BIT);
   localparam logic [2:0] UART_CTRL_WORD = 3'(1 << IO_UART_CTRL_BIT);

   logic              io_sel;
   logic [29:0]       word_idx;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_hit;
   logic [2:0]        io_word;
   logic              wr_any;
   logic              leds_wr;
   logic              uart_wr;
   logic              unused_addr_bits;

   assign io_sel           = bus.mem_addr[IO_BIT];
   assign word_idx         = bus.mem_addr[31:2];
   assign ram_addr         = word_idx[ADDR_W-1:0];
   assign ram_hit          = !io_sel && (word_idx < 30'(MEM_WORDS));
   assign io_word          = bus.mem_addr[4:2];
   assign wr_any           = |bus.mem_wmask;
   assign leds_wr          = io_sel && wr_any && (io_word == LEDS_WORD);
   assign uart_wr          = io_sel && wr_any && (io_word == UART_DATA_WORD);
   assign unused_addr_bits = ^bus.mem_addr[1:0];

   // Block RAM: synchronous read, no reset, read-before-write on collision.
   logic [31:0] ram [MEM_WORDS];
   logic [31:0] ram_dout;

   always_ff @(posedge clk) begin
      if (bus.mem_rstrb) begin
         ram_dout <= ram[ram_addr];
      end
      if (ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_wmask[b]) begin
               ram[ram_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
         end
      end
   end

   logic [31:0] io_rdata;
   logic [31:0] io_q;
   rd_src_e     rd_src_q;
   logic [4:0]  leds_q;

   always_comb begin
      io_rdata = '0;
      case (io_word)
         LEDS_WORD:      io_rdata = {27'b0, leds_q};
         UART_CTRL_WORD: io_rdata[UART_BUSY_BIT] = uart_busy;
         default:        io_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_src_q <= RdZero;
         io_q     <= '0;
         leds_q   <= '0;
      end else begin
         if (bus.mem_rstrb) begin
            io_q     <= io_rdata;
            rd_src_q <= io_sel ? RdIo : (ram_hit ? RdRam : RdZero);
         end
         if (leds_wr) begin
            leds_q <= bus.mem_wdata[4:0];
         end
      end
   end

   always_comb begin
      case (rd_src_q)
         RdRam:   bus.mem_rdata = ram_dout;
         RdIo:    bus.mem_rdata = io_q;
         default: bus.mem_rdata = '0;
      endcase
   end

   assign leds = leds_q;

   uart_tx_8n1 #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) u_uart (
      .clk   (clk),
      .rst_n (rst_n),
      .valid (uart_wr),
      .data  (bus.mem_wdata[7:0]),
      .tx    (uart_tx),
      .busy  (uart_busy)
   );

endmodule

// File: tb/tb_soc_memory.sv
// Directed plus randomized bench for soc_memory against an array/arithmetic reference model.
module tb_soc_memory;

   localparam int unsigned MW = 48;
   localparam logic [31:0] A_LEDS = 32'h0040_0004;
   localparam logic [31:0] A_UDAT = 32'h0040_0008;
   localparam logic [31:0] A_UCTL = 32'h0040_0010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] leds;
   logic       uart_tx;
   logic       uart_busy;

   soc_memory_if bus();

   soc_memory #(
      .MEM_WORDS   (MW),
      .INIT_FILE   (""),
      .CLK_FREQ_HZ (10),
      .BAUD        (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .leds      (leds),
      .uart_tx   (uart_tx),
      .uart_busy (uart_busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mdl [MW];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (m[b]) r = (r & ~(32'hFF << (8 * b))) | (nw & (32'hFF << (8 * b)));
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      if (!a[22] && (a[31:2] < MW) && (m != 4'h0)) mdl[a[31:2]] = merge(mdl[a[31:2]], d, m);
   endtask

   task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      bus.mem_addr  = a;
      bus.mem_wdata = d;
      bus.mem_wmask = m;
      bus.mem_rstrb = 1'b0;
      tick();
      bus.mem_wmask = 4'h0;
      model_write(a, d, m);
   endtask

   task automatic read(input logic [31:0] a, output logic [31:0] rd);
      bus.mem_addr  = a;
      bus.mem_rstrb = 1'b1;
      tick();
      bus.mem_rstrb = 1'b0;
      rd = bus.mem_rdata;
   endtask

   task automatic run_frame(input logic [7:0] b, input bit extras);
      logic [9:0]  frame;
      logic [31:0] rd;
      int          bad;
      frame = {1'b1, b, 1'b0};
      write(A_UDAT, {24'h0, b}, 4'hF);
      for (int k = 0; k < 100; k++) begin
         chk("uart_busy_frame", 32'(uart_busy), 32'd1);
         chk("uart_tx_slot", 32'(uart_tx), 32'(frame[k / 10]));
         if (extras && k == 30) begin
            bus.mem_addr  = A_UCTL;
            bus.mem_rstrb = 1'b1;
         end
         if (extras && k == 31) begin
            bus.mem_rstrb = 1'b0;
            chk("uart_ctrl_read", bus.mem_rdata, 32'h200);
         end
         if (extras && k == 45) begin
            bus.mem_addr  = A_UDAT;
            bus.mem_wdata = 32'h5A;
            bus.mem_wmask = 4'hF;
         end
         if (extras && k == 46) bus.mem_wmask = 4'h0;
         tick();
      end
      chk("uart_busy_end", 32'(uart_busy), 32'd0);
      chk("uart_tx_end", 32'(uart_tx), 32'd1);
      bad = 0;
      for (int k = 0; k < 120; k++) begin
         if (uart_busy !== 1'b0 || uart_tx !== 1'b1) bad++;
         tick();
      end
      chk("uart_no_second_frame", 32'(bad), 32'd0);
      read(A_UCTL, rd);
      chk("uart_ctrl_idle", rd, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] exp_rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
      int          idx;
      int          bad;

      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      bus.mem_rstrb = 1'b0;
      #1;
      chk("reset_rdata", bus.mem_rdata, 32'h0);
      chk("reset_leds", 32'(leds), 32'h0);
      chk("reset_tx", 32'(uart_tx), 32'd1);
      chk("reset_busy", 32'(uart_busy), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < int'(MW); i++) write(32'(i * 4), $urandom, 4'hF);

      // Word 0 holds the reset-vector instruction.
      write(32'h0, 32'h0000_0013, 4'hF);
      read(32'h0, rd);
      chk("ram_word0", rd, 32'h0000_0013);
      tick();
      tick();
      chk("ram_word0_hold", bus.mem_rdata, 32'h0000_0013);

      write(32'h10, 32'h0, 4'hF);
      write(32'h10, 32'hAABB_CCDD, 4'b0101);
      read(32'h10, rd);
      chk("byte_mask", rd, mdl[4]);
      chk("byte_mask_const", rd, 32'h00BB_00DD);
      write(32'h10, 32'h0, 4'hF);
      bus.mem_addr  = 32'h10;
      bus.mem_wdata = 32'hAABB_CCDD;
      bus.mem_wmask = 4'b0101;
      bus.mem_rstrb = 1'b1;
      tick();
      bus.mem_wmask = 4'h0;
      bus.mem_rstrb = 1'b0;
      model_write(32'h10, 32'hAABB_CCDD, 4'b0101);
      chk("read_before_write", bus.mem_rdata, 32'h0);
      read(32'h10, rd);
      chk("after_collision", rd, 32'h00BB_00DD);

      exp_rd = rd;
      for (int i = 0; i < 300; i++) begin
         idx = $urandom_range(0, MW + 3);
         a   = {idx[29:0], 2'($urandom)};
         d   = $urandom;
         m   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
         bus.mem_addr  = a;
         bus.mem_wdata = d;
         bus.mem_wmask = m;
         bus.mem_rstrb = 1'($urandom);
         if (bus.mem_rstrb) exp_rd = (idx < int'(MW)) ? mdl[idx] : 32'h0;
         tick();
         model_write(a, d, m);
         chk("rand_rdata", bus.mem_rdata, exp_rd);
      end
      bus.mem_wmask = 4'h0;
      bus.mem_rstrb = 1'b0;

      write(A_LEDS, 32'h3F, 4'h1);
      chk("leds_write", 32'(leds), 32'h1F);
      read(A_LEDS, rd);
      chk("leds_read", rd, 32'h1F);
      for (int i = 0; i < 4; i++) begin
         d = $urandom;
         write(A_LEDS, d, 4'(1 << i));
         chk("leds_rand", 32'(leds), 32'(d[4:0]));
      end
      write(A_LEDS, ~d, 4'h0);
      chk("leds_zero_mask", 32'(leds), 32'(d[4:0]));
      read(A_UDAT, rd);
      chk("uart_data_read", rd, 32'h0);
      read(32'h0040_0014, rd);
      chk("unmapped_read", rd, 32'h0);
      write(A_UCTL, 32'hFF, 4'hF);
      tick();
      chk("ctrl_write_ignored", 32'(uart_busy), 32'd0);

      read(A_LEDS, rd);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_leds", 32'(leds), 32'h0);
      chk("async_reset_rdata", bus.mem_rdata, 32'h0);
      #1;
      rst_n = 1'b1;
      read(32'h0, rd);
      chk("ram_survives_reset", rd, mdl[0]);

      run_frame(8'hA5, 1'b1);
      run_frame(8'($urandom), 1'b0);

      write(A_UDAT, 32'h0000_00C3, 4'hF);
      repeat (35) tick();
      #1;
      rst_n = 1'b0;
      #1;
      chk("midframe_reset_tx", 32'(uart_tx), 32'd1);
      chk("midframe_reset_busy", 32'(uart_busy), 32'd0);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (uart_busy !== 1'b0 || uart_tx !== 1'b1) bad++;
      end
      chk("frame_abandoned", 32'(bad), 32'd0);
      run_frame(8'($urandom), 1'b0);

      read(32'h0, rd);
      chk("word0_before_oob", rd, mdl[0]);
      read(32'(4 * MW), rd);
      chk("oob_read", rd, 32'h0);
      write(32'(4 * MW), ~mdl[0], 4'hF);
      read(32'h0, rd);
      chk("oob_write_no_alias", rd, mdl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
